// File: rtl/decode_stage.sv
// Decode stage: IF/ID register, RV32I-subset decoder, 32x32 register file with
// optional write-through from W, immediate extension and the ID/EX register.
module decode_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter bit          WB_BYPASS = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] InstrF,
    input  logic [31:0] PCF,
    input  logic [31:0] PCPlus4F,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        FlushE,
    input  logic        RegWriteW,
    input  logic [4:0]  RdW,
    input  logic [31:0] ResultW,
    output logic [4:0]  Rs1D,
    output logic [4:0]  Rs2D,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCE,
    output logic [31:0] PCPlus4E,
    output logic [4:0]  Rs1E,
    output logic [4:0]  Rs2E,
    output logic [4:0]  RdE,
    output logic        IllegalE
);

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_IMM    = 7'b0010011,
        OP_BRANCH = 7'b1100011,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } alu_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } res_src_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4
    } imm_sel_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic        alu_src;
        logic [1:0]  result_src;
        logic [2:0]  alu_control;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm_ext;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        illegal;
    } id_ex_t;

    // IF/ID register
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;

    always_comb begin
        instr_d    = instr_q;
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        if (FlushD) begin
            instr_d    = NOP_INSTR;
            pc_d       = '0;
            pc_plus4_d = '0;
        end else if (!StallD) begin
            instr_d    = InstrF;
            pc_d       = PCF;
            pc_plus4_d = PCPlus4F;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            instr_q    <= NOP_INSTR;
            pc_q       <= '0;
            pc_plus4_q <= '0;
        end else begin
            instr_q    <= instr_d;
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
        end
    end

    // Register file
    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    always_comb begin
        regs_d = regs_q;
        if (RegWriteW && (RdW != '0)) begin
            regs_d[RdW] = ResultW;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int unsigned i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  funct3;
    logic [31:0] rd1, rd2;

    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign Rs1D   = rs1;
    assign Rs2D   = rs2;

    // x0 is hardwired; the W write-through never applies to it
    always_comb begin
        if (rs1 == '0) begin
            rd1 = '0;
        end else if (WB_BYPASS && RegWriteW && (RdW == rs1)) begin
            rd1 = ResultW;
        end else begin
            rd1 = regs_q[rs1];
        end
        if (rs2 == '0) begin
            rd2 = '0;
        end else if (WB_BYPASS && RegWriteW && (RdW == rs2)) begin
            rd2 = ResultW;
        end else begin
            rd2 = regs_q[rs2];
        end
    end

    // ALU operation shared by register and immediate arithmetic forms
    alu_e f3_alu;
    logic f3_ok;

    always_comb begin
        f3_alu = ALU_ADD;
        f3_ok  = 1'b1;
        case (funct3)
            3'b000:  f3_alu = ALU_ADD;
            3'b010:  f3_alu = ALU_SLT;
            3'b110:  f3_alu = ALU_OR;
            3'b111:  f3_alu = ALU_AND;
            default: f3_ok  = 1'b0;
        endcase
    end

    id_ex_t   dec;
    imm_sel_e imm_sel;

    always_comb begin
        dec     = '0;
        imm_sel = IMM_NONE;
        case (instr_q[6:0])
            OP_LOAD: begin
                if (funct3 == 3'b010) begin
                    dec.reg_write  = 1'b1;
                    dec.result_src = RES_MEM;
                    dec.alu_src    = 1'b1;
                    imm_sel        = IMM_I;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_STORE: begin
                if (funct3 == 3'b010) begin
                    dec.mem_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    imm_sel       = IMM_S;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_REG: begin
                if (f3_ok) begin
                    dec.reg_write   = 1'b1;
                    dec.alu_control = ((funct3 == 3'b000) && instr_q[30]) ? ALU_SUB : f3_alu;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_IMM: begin
                if (f3_ok) begin
                    dec.reg_write   = 1'b1;
                    dec.alu_src     = 1'b1;
                    dec.alu_control = f3_alu;
                    imm_sel         = IMM_I;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == 3'b000) begin
                    dec.branch      = 1'b1;
                    dec.alu_control = ALU_SUB;
                    imm_sel         = IMM_B;
                end else begin
                    dec.illegal = 1'b1;
                end
            end
            OP_JAL: begin
                dec.reg_write  = 1'b1;
                dec.jump       = 1'b1;
                dec.result_src = RES_PC4;
                imm_sel        = IMM_J;
            end
            default: dec.illegal = 1'b1;
        endcase

        // R-type and illegal encodings carry a zero immediate
        case (imm_sel)
            IMM_I:   dec.imm_ext = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S:   dec.imm_ext = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B:   dec.imm_ext = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                                    instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_J:   dec.imm_ext = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                                    instr_q[20], instr_q[30:21], 1'b0};
            default: dec.imm_ext = '0;
        endcase

        dec.rd1      = rd1;
        dec.rd2      = rd2;
        dec.pc       = pc_q;
        dec.pc_plus4 = pc_plus4_q;
        dec.rs1      = rs1;
        dec.rs2      = rs2;
        dec.rd       = rd;
    end

    // ID/EX register
    id_ex_t ex_q, ex_d;

    always_comb begin
        ex_d = dec;
        if (FlushE) begin
            ex_d = '0;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign JumpE       = ex_q.jump;
    assign BranchE     = ex_q.branch;
    assign ALUSrcE     = ex_q.alu_src;
    assign ResultSrcE  = ex_q.result_src;
    assign ALUControlE = ex_q.alu_control;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign ImmExtE     = ex_q.imm_ext;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc_plus4;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign IllegalE    = ex_q.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: decode vector table plus hand sequences for bypass,
// stall/flush interaction and asynchronous reset; results checked via a scoreboard.
module tb_decode_stage;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] InstrF, PCF, PCPlus4F;
    logic        StallD, FlushD, FlushE, RegWriteW;
    logic [4:0]  RdW;
    logic [31:0] ResultW;
    logic [4:0]  Rs1D, Rs2D;
    logic        RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic        IllegalE;

    always #5 CLK = ~CLK;

    decode_stage #(.NOP_INSTR(32'h0000_0013), .WB_BYPASS(1'b1)) dut (
        .CLK(CLK), .RST_N(RST_N), .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F),
        .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE), .RegWriteW(RegWriteW),
        .RdW(RdW), .ResultW(ResultW), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .BranchE(BranchE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .IllegalE(IllegalE)
    );

    typedef struct packed {
        logic        rw, mw, jmp, br, asrc;
        logic [1:0]  rsrc;
        logic [2:0]  alu;
        logic [31:0] rd1, rd2, imm, pc, pc4;
        logic [4:0]  rs1, rs2, rd;
        logic        ill;
    } ev_t;

    typedef struct { int due; string name; ev_t e; } sb_t;
    typedef struct { string name; logic [31:0] instr; ev_t e; } vec_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    sb_t  sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;

    function automatic ev_t mk(input logic rw, mw, jmp, br, asrc, input logic [1:0] rsrc,
                               input logic [2:0] alu, input logic [31:0] rd1, rd2, imm,
                               input logic [4:0] rs1, rs2, rd, input logic ill);
        ev_t e;
        e = '0;
        e.rw = rw; e.mw = mw; e.jmp = jmp; e.br = br; e.asrc = asrc;
        e.rsrc = rsrc; e.alu = alu; e.rd1 = rd1; e.rd2 = rd2; e.imm = imm;
        e.rs1 = rs1; e.rs2 = rs2; e.rd = rd; e.ill = ill;
        return e;
    endfunction

    function automatic ev_t snap();
        ev_t s;
        s.rw = RegWriteE; s.mw = MemWriteE; s.jmp = JumpE; s.br = BranchE; s.asrc = ALUSrcE;
        s.rsrc = ResultSrcE; s.alu = ALUControlE; s.rd1 = RD1E; s.rd2 = RD2E;
        s.imm = ImmExtE; s.pc = PCE; s.pc4 = PCPlus4E; s.rs1 = Rs1E; s.rs2 = Rs2E;
        s.rd = RdE; s.ill = IllegalE;
        return s;
    endfunction

    task automatic check_ev(input string name, input ev_t act, input ev_t exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    task automatic expect_at(input int d, input string name, input ev_t e);
        sb.push_back('{cyc + d, name, e});
    endtask

    task automatic drive(input logic [31:0] instr, pc, input logic stall, fd, fe, wen,
                         input logic [4:0] wrd, input logic [31:0] wres);
        InstrF = instr; PCF = pc; PCPlus4F = pc + 32'd4;
        StallD = stall; FlushD = fd; FlushE = fe;
        RegWriteW = wen; RdW = wrd; ResultW = wres;
        @(posedge CLK);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                check_ev(sb[i].name, snap(), sb[i].e);
                sb.delete(i);
            end
        end
    endtask

    task automatic nop_cycle(input logic [31:0] pc);
        drive(NOP, pc, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        ev_t nop_e, e;
        logic [31:0] pc;

        nop_e = mk(1, 0, 0, 0, 1, 2'b00, 3'b000, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 0);

        vecs.push_back('{"lw",        32'h00A12283, mk(1,0,0,0,1,2'b01,3'b000,32'h100,32'h0,32'd10,5'd2,5'd10,5'd5,0)});
        vecs.push_back('{"sw_neg",    32'hFE512E23, mk(0,1,0,0,1,2'b00,3'b000,32'h100,32'h1234,32'hFFFFFFFC,5'd2,5'd5,5'd28,0)});
        vecs.push_back('{"add",       32'h00510333, mk(1,0,0,0,0,2'b00,3'b000,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd6,0)});
        vecs.push_back('{"sub",       32'h405103B3, mk(1,0,0,0,0,2'b00,3'b001,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd7,0)});
        vecs.push_back('{"slt",       32'h00512433, mk(1,0,0,0,0,2'b00,3'b101,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd8,0)});
        vecs.push_back('{"or",        32'h005164B3, mk(1,0,0,0,0,2'b00,3'b011,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd9,0)});
        vecs.push_back('{"and",       32'h00517533, mk(1,0,0,0,0,2'b00,3'b010,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd10,0)});
        vecs.push_back('{"addi_neg",  32'hFFF18093, mk(1,0,0,0,1,2'b00,3'b000,32'h55,32'h0,32'hFFFFFFFF,5'd3,5'd31,5'd1,0)});
        vecs.push_back('{"addi_b30",  32'h40018093, mk(1,0,0,0,1,2'b00,3'b000,32'h55,32'h0,32'h400,5'd3,5'd0,5'd1,0)});
        vecs.push_back('{"andi",      32'h0F01F213, mk(1,0,0,0,1,2'b00,3'b010,32'h55,32'h0,32'hF0,5'd3,5'd16,5'd4,0)});
        vecs.push_back('{"beq_neg",   32'hFE000EE3, mk(0,0,0,1,0,2'b00,3'b001,32'h0,32'h0,32'hFFFFFFFC,5'd0,5'd0,5'd29,0)});
        vecs.push_back('{"jal_pos",   32'h008000EF, mk(1,0,1,0,0,2'b10,3'b000,32'h0,32'h0,32'd8,5'd0,5'd8,5'd1,0)});
        vecs.push_back('{"jal_neg",   32'hFFDFF0EF, mk(1,0,1,0,0,2'b10,3'b000,32'h0,32'h0,32'hFFFFFFFC,5'd31,5'd29,5'd1,0)});
        vecs.push_back('{"ill_op",    32'h0000007F, mk(0,0,0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0,5'd0,5'd0,5'd0,1)});
        vecs.push_back('{"ill_sll",   32'h00511333, mk(0,0,0,0,0,2'b00,3'b000,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd6,1)});
        vecs.push_back('{"ill_slli",  32'h00119093, mk(0,0,0,0,0,2'b00,3'b000,32'h55,32'h0,32'h0,5'd3,5'd1,5'd1,1)});
        vecs.push_back('{"nop",       NOP,          nop_e});

        RST_N = 1'b0; InstrF = '0; PCF = '0; PCPlus4F = '0;
        StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; RdW = '0; ResultW = '0;
        #12;
        check_ev("reset_e_zero", snap(), '0);
        check32("reset_rs1d_nop", {27'd0, Rs1D}, 32'd0);
        RST_N = 1'b1;

        expect_at(1, "nop_after_reset", nop_e);
        drive(NOP, 32'h0, 0, 0, 0, 1, 5'd2, 32'h100);
        drive(NOP, 32'h0, 0, 0, 0, 1, 5'd3, 32'h55);
        drive(NOP, 32'h0, 0, 0, 0, 1, 5'd5, 32'h1234);

        for (int i = 0; i < vecs.size(); i++) begin
            pc = 32'h1000 + 32'(i) * 32'd4;
            e = vecs[i].e;
            e.pc = pc;
            e.pc4 = pc + 32'd4;
            expect_at(2, vecs[i].name, e);
            drive(vecs[i].instr, pc, 0, 0, 0, 0, 5'd0, 32'h0);
            if (i == 0) check32("lw_rs1d", {27'd0, Rs1D}, 32'd2);
        end
        nop_cycle(32'h1F00);
        nop_cycle(32'h1F04);

        // W write-through to the D read of x3, then the x0 cases
        e = mk(1,0,0,0,0,2'b00,3'b000,32'hDEAD,32'h0,32'h0,5'd3,5'd0,5'd11,0);
        e.pc = 32'h2000; e.pc4 = 32'h2004;
        expect_at(2, "bypass_rd1", e);
        drive(32'h000185B3, 32'h2000, 0, 0, 0, 0, 5'd0, 32'h0);
        drive(NOP, 32'h2004, 0, 0, 0, 1, 5'd3, 32'hDEAD);
        e = mk(1,0,0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0,5'd0,5'd0,5'd12,0);
        e.pc = 32'h2008; e.pc4 = 32'h200C;
        expect_at(2, "x0_no_bypass", e);
        drive(32'h00000633, 32'h2008, 0, 0, 0, 0, 5'd0, 32'h0);
        drive(NOP, 32'h200C, 0, 0, 0, 1, 5'd0, 32'hBEEF);
        e.pc = 32'h2010; e.pc4 = 32'h2014;
        expect_at(2, "x0_not_written", e);
        drive(32'h00000633, 32'h2010, 0, 0, 0, 0, 5'd0, 32'h0);
        e = mk(1,0,0,0,0,2'b00,3'b000,32'hDEAD,32'h0,32'h0,5'd3,5'd0,5'd11,0);
        e.pc = 32'h2014; e.pc4 = 32'h2018;
        expect_at(2, "x3_written", e);
        drive(32'h000185B3, 32'h2014, 0, 0, 0, 0, 5'd0, 32'h0);
        nop_cycle(32'h2018);
        nop_cycle(32'h201C);

        // load-use: StallD+FlushE together, with a W write in the same cycle
        e = mk(1,0,0,0,0,2'b00,3'b000,32'h77,32'h0,32'h0,5'd13,5'd0,5'd14,0);
        e.pc = 32'h3000; e.pc4 = 32'h3004;
        expect_at(3, "held_after_stall", e);
        drive(32'h00068733, 32'h3000, 0, 0, 0, 0, 5'd0, 32'h0);
        expect_at(1, "stall_flushe_bubble", '0);
        drive(32'h005164B3, 32'h3004, 1, 0, 1, 1, 5'd13, 32'h77);
        check32("stall_holds_rs1d", {27'd0, Rs1D}, 32'd13);
        e = mk(1,0,0,0,0,2'b00,3'b011,32'h100,32'h1234,32'h0,5'd2,5'd5,5'd9,0);
        e.pc = 32'h3004; e.pc4 = 32'h3008;
        expect_at(2, "after_stall_next", e);
        drive(32'h005164B3, 32'h3004, 0, 0, 0, 0, 5'd0, 32'h0);
        nop_cycle(32'h3008);

        // FlushD has priority over StallD
        expect_at(2, "flushd_wins", nop_e);
        drive(32'h00510333, 32'h4000, 1, 1, 0, 0, 5'd0, 32'h0);
        check32("flushd_rs2d_nop", {27'd0, Rs2D}, 32'd0);
        nop_cycle(32'h4004);
        nop_cycle(32'h4008);

        // asynchronous reset mid-cycle with a lw in flight, W write during reset lost
        drive(32'h00A12283, 32'h5000, 0, 0, 0, 0, 5'd0, 32'h0);
        #2;
        RST_N = 1'b0;
        #1;
        check_ev("midreset_e_zero", snap(), '0);
        check32("midreset_rs1d_nop", {27'd0, Rs1D}, 32'd0);
        drive(NOP, 32'h5004, 0, 0, 0, 1, 5'd20, 32'h99);
        RST_N = 1'b1;
        expect_at(1, "nop_after_midreset", nop_e);
        e = mk(1,0,0,0,0,2'b00,3'b000,32'h0,32'h0,32'h0,5'd2,5'd20,5'd15,0);
        e.pc = 32'h6000; e.pc4 = 32'h6004;
        expect_at(2, "rf_cleared", e);
        drive(32'h014107B3, 32'h6000, 0, 0, 0, 0, 5'd0, 32'h0);
        nop_cycle(32'h6004);
        nop_cycle(32'h6008);

        foreach (sb[i]) begin
            n_checks++;
            $display("FAIL %s: never compared, due cycle %0d, now %0d", sb[i].name, sb[i].due, cyc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
